vs_regfile_param: RTL and testbench
===================================

# vs_regfile_param

Parametrised scalar/vector register file for the SIMD filter core: `NSREG` scalar and `NVREG` vector registers of `LANES` × `DW` bits, two asynchronous read ports, one lane-masked write port with three write modes, and same-cycle write-to-read forwarding. It adds a post-reset preset sequencer and a pending-write scoreboard, replacing the fixed 16-lane negedge register file between decode and execute.

## Interface
- `LANES`, 16, vector lanes; lane `LANES-1` is the scalar lane.
- `DW`, 32, lane width in bits.
- `NVREG`, 16, vector register count (≥5).
- `NSREG`, 16, scalar register count; index `NSREG-1` aliases `pc_in`.
- `AW`, `$clog2(max(NVREG,NSREG))`, index width (derived).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ra1`, `ra2` in `AW`: read indices.
- `rd_vs1`, `rd_vs2` in 1: read select per port (0 scalar, 1 vector).
- `rd1`, `rd2` out `LANES*DW`: read data.
- `busy1`, `busy2` out 1: scoreboard bit of the register addressed by the port.
- `pc_in` in `DW`: value returned for scalar index `NSREG-1`.
- `we` in 1: write enable.
- `wa` in `AW`: write index.
- `wmode` in 2: 00 scalar, 01 vector masked, 10 broadcast, 11 reserved (write ignored).
- `wmask` in `LANES`: lane mask for modes 01/10.
- `wd` in `LANES*DW`: write data.
- `rsv` in 1, `rsv_vs` in 1, `rsv_idx` in `AW`: reserve (mark busy) a scalar/vector register.
- `ready` out 1: preset sequence complete; writes/reserves accepted.
- `dbg_s0` out `DW`: scalar register 0, for the probe.

## Operation
- Scalar read (`rd_vs`=0): lane `LANES-1` = `pc_in` if index = `NSREG-1`, else scalar reg; lanes `0..LANES-2` = vector reg[index] lanes (matches existing consumers). Vector read: all lanes of vector reg[index]. Index out of range → zeros.
- Write modes (only when `we` && `ready`):
  - 00: scalar[wa] ← `wd` lane `LANES-1`; `wmask` ignored; `wa`=`NSREG-1` discarded.
  - 01: vector[wa] lane i ← `wd` lane i for each set `wmask[i]`.
  - 10: vector[wa] lane i ← `wd` lane `LANES-1` for each set `wmask[i]`.
- Forwarding: a read port addressing the register being written in the same cycle returns the post-write value (masked lanes new, others old). `pc_in` alias has priority over forwarding.
- Scoreboard: one busy bit per scalar and per vector register. `rsv` sets the bit, a write to that register clears it. Same-register reserve and write in one cycle → bit stays set (new producer wins). Reserves are ignored while `ready`=0.
- Preset FSM, states INIT → RUN:
  - `rst` → INIT, counter = 0, all scalars and busy bits cleared.
  - INIT writes vector[counter] once per cycle: all lanes 0, except lane `LANES-1` of `NVREG-1..NVREG-5` = 1, 16, 0, 48, 48 (increment-1, increment-16, coefficient base, sample base, output base).
  - Counter wraps at `NVREG-1` → RUN.

## Timing
- Reset values: `ready`=0, `busy1`/`busy2`=0, `dbg_s0`=0; `rd1`/`rd2` are combinational from cleared and presetting state.
- `ready` rises exactly `NVREG` cycles after the first cycle with `rst` low; it stays high until the next `rst`.
- `rst` asserted mid-INIT or in RUN restarts INIT on the next edge; vector contents are valid only after `ready`.
- Write latency: committed at the edge; visible combinationally in the same cycle via forwarding, from storage from the next cycle.
- Busy latency: set or clear is visible on `busy*` the cycle after the edge; no forwarding of busy.

## Test plan
- Release `rst`, `NVREG`=16: `ready` low 16 cycles, high on cycle 16. vec15 lane15 = 1, vec14 = 16, vec12 = 48, vec11 = 48; every other lane 0.
- Mode 01 write vec3, `wmask`=0x00FF, `wd` lanes = lane index: same-cycle read `ra1`=3 vector shows lanes 0–7 = 0..7, lanes 8–15 keep their old value. Next cycle storage matches.
- Mode 10 write vec2, `wmask`=0xFFFF, `wd` lane15 = 0xDEAD: all 16 lanes read 0xDEAD.
- Scalar write s0 = 0x40: `dbg_s0`=0x40 next cycle. Write s15 = 5 with `pc_in`=0x100: scalar read of index 15 returns 0x100.
- `rsv` vec4 → `busy1` (`ra1`=4, vector) =1. Write vec4 → `busy1`=0. Simultaneous reserve and write of vec4 → `busy1` stays 1.
- Write or `rsv` during INIT: ignored. Assert `rst` at INIT cycle 7: `ready` rises 16 cycles after release, not 9.

Source files
------------

// File: rtl/vs_regfile_param_if.sv
// Decode/execute side bus of the scalar/vector register file: two read ports,
// one lane-masked write port, busy reservation and status.
interface vs_regfile_param_if #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int NVREG = 16,
  parameter int NSREG = 16,
  parameter int AW    = $clog2((NVREG > NSREG) ? NVREG : NSREG)
) ();
  logic [AW-1:0]       ra1;
  logic [AW-1:0]       ra2;
  logic                rd_vs1;
  logic                rd_vs2;
  logic [LANES*DW-1:0] rd1;
  logic [LANES*DW-1:0] rd2;
  logic                busy1;
  logic                busy2;
  logic [DW-1:0]       pc_in;
  logic                we;
  logic [AW-1:0]       wa;
  logic [1:0]          wmode;
  logic [LANES-1:0]    wmask;
  logic [LANES*DW-1:0] wd;
  logic                rsv;
  logic                rsv_vs;
  logic [AW-1:0]       rsv_idx;
  logic                ready;
  logic [DW-1:0]       dbg_s0;

  modport master (
    output ra1, ra2, rd_vs1, rd_vs2, pc_in, we, wa, wmode, wmask, wd,
           rsv, rsv_vs, rsv_idx,
    input  rd1, rd2, busy1, busy2, ready, dbg_s0
  );

  modport slave (
    input  ra1, ra2, rd_vs1, rd_vs2, pc_in, we, wa, wmode, wmask, wd,
           rsv, rsv_vs, rsv_idx,
    output rd1, rd2, busy1, busy2, ready, dbg_s0
  );
endinterface

// File: rtl/vs_regfile_param.sv
// Scalar/vector register file with same-cycle write forwarding, a pending-write
// scoreboard and a post-reset sequencer that presets the vector registers.
//
// state   | meaning
// ST_INIT | presetting vector[cnt] one per cycle; writes and reserves ignored
// ST_RUN  | normal operation; ready high until the next rst
module vs_regfile_param #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int NVREG = 16,
  parameter int NSREG = 16,
  parameter int AW    = $clog2((NVREG > NSREG) ? NVREG : NSREG)
) (
  input logic              clk,
  input logic              rst,
  vs_regfile_param_if.slave bus
);

  localparam int VW  = LANES * DW;
  localparam int TOP = (LANES - 1) * DW;

  localparam logic [AW:0]   NV_LIM   = (AW+1)'(NVREG);
  localparam logic [AW:0]   NS_LIM   = (AW+1)'(NSREG);
  localparam logic [AW-1:0] NS_PC    = AW'(NSREG - 1);
  localparam logic [AW-1:0] CNT_LAST = AW'(NVREG - 1);
  localparam logic [AW-1:0] V_INC1   = AW'(NVREG - 1);
  localparam logic [AW-1:0] V_INC16  = AW'(NVREG - 2);
  localparam logic [AW-1:0] V_SMP    = AW'(NVREG - 4);
  localparam logic [AW-1:0] V_OUT    = AW'(NVREG - 5);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            ready_q;

  logic [VW-1:0]   vreg [NVREG];
  logic [DW-1:0]   sreg [NSREG];
  logic [NVREG-1:0] busy_v;
  logic [NSREG-1:0] busy_s;

  logic            acc;
  logic            wa_v_ok;
  logic            wa_s_ok;
  logic            rsv_v_ok;
  logic            rsv_s_ok;
  logic            wr_s_en;
  logic            wr_v_en;
  logic            rsv_en;
  logic [VW-1:0]   v_old;
  logic [VW-1:0]   v_new;

  // Coefficient base (NVREG-3) is 0, so it shares the all-zero default.
  function automatic logic [VW-1:0] preset(input logic [AW-1:0] idx);
    logic [VW-1:0] p;
    p = '0;
    if (idx == V_INC1)
      p[TOP +: DW] = DW'(1);
    else if (idx == V_INC16)
      p[TOP +: DW] = DW'(16);
    else if (idx == V_SMP || idx == V_OUT)
      p[TOP +: DW] = DW'(48);
    return p;
  endfunction

  assign acc      = ready_q && !rst;
  assign wa_v_ok  = ({1'b0, bus.wa} < NV_LIM);
  assign wa_s_ok  = ({1'b0, bus.wa} < NS_LIM) && (bus.wa != NS_PC);
  assign rsv_v_ok = ({1'b0, bus.rsv_idx} < NV_LIM);
  assign rsv_s_ok = ({1'b0, bus.rsv_idx} < NS_LIM);
  assign wr_s_en  = acc && bus.we && (bus.wmode == 2'b00) && wa_s_ok;
  assign wr_v_en  = acc && bus.we && ((bus.wmode == 2'b01) || (bus.wmode == 2'b10)) && wa_v_ok;
  assign rsv_en   = acc && bus.rsv;

  assign v_old = wa_v_ok ? vreg[bus.wa] : '0;

  always_comb begin
    v_new = v_old;
    for (int i = 0; i < LANES; i++) begin
      if (bus.wmask[i]) begin
        if (bus.wmode == 2'b10)
          v_new[i*DW +: DW] = bus.wd[TOP +: DW];
        else
          v_new[i*DW +: DW] = bus.wd[i*DW +: DW];
      end
    end
  end

  // Scalar reads carry the vector register in the low lanes; the pc alias
  // overrides forwarding in the scalar lane.
  function automatic logic [VW-1:0] read_port(input logic [AW-1:0] idx, input logic vs);
    logic [VW-1:0] v;
    logic [VW-1:0] r;
    logic          in_v;
    logic          in_s;
    in_v = ({1'b0, idx} < NV_LIM);
    in_s = ({1'b0, idx} < NS_LIM);
    v = '0;
    if (in_v)
      v = (wr_v_en && (idx == bus.wa)) ? v_new : vreg[idx];
    r = '0;
    if (vs) begin
      r = v;
    end else if (in_s) begin
      r = v;
      if (idx == NS_PC)
        r[TOP +: DW] = bus.pc_in;
      else if (wr_s_en && (idx == bus.wa))
        r[TOP +: DW] = bus.wd[TOP +: DW];
      else
        r[TOP +: DW] = sreg[idx];
    end
    return r;
  endfunction

  function automatic logic busy_sel(input logic [AW-1:0] idx, input logic vs);
    logic b;
    b = 1'b0;
    if (vs) begin
      if ({1'b0, idx} < NV_LIM)
        b = busy_v[idx];
    end else begin
      if ({1'b0, idx} < NS_LIM)
        b = busy_s[idx];
    end
    return b;
  endfunction

  assign bus.rd1    = read_port(bus.ra1, bus.rd_vs1);
  assign bus.rd2    = read_port(bus.ra2, bus.rd_vs2);
  assign bus.busy1  = busy_sel(bus.ra1, bus.rd_vs1);
  assign bus.busy2  = busy_sel(bus.ra2, bus.rd_vs2);
  assign bus.ready  = ready_q;
  assign bus.dbg_s0 = sreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == CNT_LAST) begin
            state   <= ST_RUN;
            cnt     <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN:  ready_q <= 1'b1;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Vector storage is not reset; the sequencer rewrites every entry after rst.
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_INIT))
      vreg[cnt] <= preset(cnt);
    else if (wr_v_en)
      vreg[bus.wa] <= v_new;
  end

  // A reserve listed after the clear lets the new producer win on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSREG; i++)
        sreg[i] <= '0;
      busy_v <= '0;
      busy_s <= '0;
    end else begin
      if (wr_s_en) begin
        sreg[bus.wa]   <= bus.wd[TOP +: DW];
        busy_s[bus.wa] <= 1'b0;
      end
      if (wr_v_en)
        busy_v[bus.wa] <= 1'b0;
      if (rsv_en && bus.rsv_vs && rsv_v_ok)
        busy_v[bus.rsv_idx] <= 1'b1;
      if (rsv_en && !bus.rsv_vs && rsv_s_ok)
        busy_s[bus.rsv_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vs_regfile_param.sv
// Directed and randomized bench for vs_regfile_param against a lane-level
// reference model of the register file, scoreboard and preset sequence.
module tb_vs_regfile_param;
  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int NVREG = 16;
  localparam int NSREG = 16;
  localparam int AW    = 4;
  localparam int VW    = LANES * DW;
  localparam int TOP   = (LANES - 1) * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] mv [NVREG][LANES];
  logic [DW-1:0] ms [NSREG];
  bit            bv [NVREG];
  bit            bs [NSREG];
  bit            m_ready = 1'b0;
  int            init_left = NVREG;
  logic [VW-1:0] expv;

  vs_regfile_param_if #(.LANES(LANES), .DW(DW), .NVREG(NVREG), .NSREG(NSREG), .AW(AW)) bus ();

  vs_regfile_param #(.LANES(LANES), .DW(DW), .NVREG(NVREG), .NSREG(NSREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane LANES-1 of the last five vectors: inc-1, inc-16, coef base, sample base, output base.
  function automatic logic [DW-1:0] preset_lane(int v, int l);
    if (l != LANES - 1) return '0;
    case (NVREG - 1 - v)
      0:       return DW'(1);
      1:       return DW'(16);
      3, 4:    return DW'(48);
      default: return '0;
    endcase
  endfunction

  function automatic logic [VW-1:0] exp_read(int idx, bit vs);
    logic [DW-1:0] lane [LANES];
    logic [VW-1:0] r;
    bit            live;
    live = m_ready && !rst && bus.we;
    for (int l = 0; l < LANES; l++) begin
      lane[l] = mv[idx][l];
      if (live && int'(bus.wa) == idx && bus.wmask[l]) begin
        if (bus.wmode == 2'd1)      lane[l] = bus.wd[l*DW +: DW];
        else if (bus.wmode == 2'd2) lane[l] = bus.wd[TOP +: DW];
      end
    end
    if (!vs) begin
      if (idx == NSREG - 1)
        lane[LANES-1] = bus.pc_in;
      else if (live && bus.wmode == 2'd0 && int'(bus.wa) == idx)
        lane[LANES-1] = bus.wd[TOP +: DW];
      else
        lane[LANES-1] = ms[idx];
    end
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = lane[l];
    return r;
  endfunction

  function automatic bit exp_busy(int idx, bit vs);
    return vs ? bv[idx] : bs[idx];
  endfunction

  task automatic commit();
    int w;
    w = int'(bus.wa);
    if (rst) begin
      for (int i = 0; i < NSREG; i++) begin ms[i] = '0; bs[i] = 1'b0; end
      for (int i = 0; i < NVREG; i++) bv[i] = 1'b0;
      m_ready   = 1'b0;
      init_left = NVREG;
    end else if (!m_ready) begin
      init_left--;
      if (init_left == 0) begin
        m_ready = 1'b1;
        for (int v = 0; v < NVREG; v++)
          for (int l = 0; l < LANES; l++) mv[v][l] = preset_lane(v, l);
      end
    end else begin
      if (bus.we && bus.wmode == 2'd0 && w != NSREG - 1) begin
        ms[w] = bus.wd[TOP +: DW];
        bs[w] = 1'b0;
      end
      if (bus.we && (bus.wmode == 2'd1 || bus.wmode == 2'd2)) begin
        for (int l = 0; l < LANES; l++)
          if (bus.wmask[l])
            mv[w][l] = (bus.wmode == 2'd1) ? bus.wd[l*DW +: DW] : bus.wd[TOP +: DW];
        bv[w] = 1'b0;
      end
      if (bus.rsv) begin
        if (bus.rsv_vs) bv[int'(bus.rsv_idx)] = 1'b1;
        else            bs[int'(bus.rsv_idx)] = 1'b1;
      end
    end
  endtask

  // Check all outputs against the model, then clock and advance the model.
  task automatic step();
    #1;
    chk("ready",  VW'(bus.ready),  VW'(m_ready));
    chk("busy1",  VW'(bus.busy1),  VW'(exp_busy(int'(bus.ra1), bus.rd_vs1)));
    chk("busy2",  VW'(bus.busy2),  VW'(exp_busy(int'(bus.ra2), bus.rd_vs2)));
    chk("dbg_s0", VW'(bus.dbg_s0), VW'(ms[0]));
    if (m_ready) begin
      chk("rd1", bus.rd1, exp_read(int'(bus.ra1), bus.rd_vs1));
      chk("rd2", bus.rd2, exp_read(int'(bus.ra2), bus.rd_vs2));
    end
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wmode = 2'd0; bus.wa = '0; bus.wmask = '0; bus.wd = '0;
    bus.rsv = 1'b0; bus.rsv_vs = 1'b0; bus.rsv_idx = '0;
    bus.ra1 = '0; bus.ra2 = '0; bus.rd_vs1 = 1'b0; bus.rd_vs2 = 1'b0;
    bus.pc_in = 32'h1234;
  endtask

  task automatic rand_wd();
    for (int l = 0; l < LANES; l++) bus.wd[l*DW +: DW] = $urandom;
  endtask

  initial begin
    idle();
    for (int v = 0; v < NVREG; v++)
      for (int l = 0; l < LANES; l++) mv[v][l] = '0;
    rst = 1'b1;
    @(posedge clk);
    commit();
    #1;
    repeat (2) step();

    // Release; writes and reserves during INIT must be dropped.
    rst = 1'b0;
    bus.we = 1'b1; bus.wmode = 2'd0; bus.wa = '0; rand_wd();
    bus.rsv = 1'b1; bus.rsv_vs = 1'b1; bus.rsv_idx = AW'(4);
    bus.ra1 = AW'(4); bus.rd_vs1 = 1'b1;
    for (int k = 0; k < NVREG; k++) step();
    idle();
    bus.ra1 = AW'(4); bus.rd_vs1 = 1'b1;
    #1;
    chk("ready_c16", VW'(bus.ready), VW'(1'b1));
    chk("init_wr_ignored", VW'(bus.dbg_s0), VW'(0));
    step();

    for (int v = 0; v < NVREG; v++) begin
      bus.ra1 = AW'(v); bus.rd_vs1 = 1'b1;
      bus.ra2 = AW'(v); bus.rd_vs2 = 1'b0;
      bus.pc_in = $urandom;
      step();
    end

    // Masked vector write with same-cycle forwarding, then from storage.
    idle();
    bus.we = 1'b1; bus.wmode = 2'd1; bus.wa = AW'(3); bus.wmask = 16'h00FF;
    for (int l = 0; l < LANES; l++) bus.wd[l*DW +: DW] = DW'(l);
    bus.ra1 = AW'(3); bus.rd_vs1 = 1'b1; bus.ra2 = AW'(3); bus.rd_vs2 = 1'b1;
    expv = '0;
    for (int l = 0; l < 8; l++) expv[l*DW +: DW] = DW'(l);
    #1;
    chk("mode01_fwd", bus.rd1, expv);
    step();
    idle();
    bus.ra1 = AW'(3); bus.rd_vs1 = 1'b1;
    #1;
    chk("mode01_store", bus.rd1, expv);
    step();

    // Broadcast.
    idle();
    bus.we = 1'b1; bus.wmode = 2'd2; bus.wa = AW'(2); bus.wmask = 16'hFFFF;
    rand_wd(); bus.wd[TOP +: DW] = 32'hDEAD;
    bus.ra1 = AW'(2); bus.rd_vs1 = 1'b1;
    expv = {LANES{32'hDEAD}};
    #1;
    chk("mode10_fwd", bus.rd1, expv);
    step();
    idle();
    bus.ra1 = AW'(2); bus.rd_vs1 = 1'b1;
    #1;
    chk("mode10_store", bus.rd1, expv);
    step();

    // Scalar write and pc alias.
    idle();
    bus.we = 1'b1; bus.wmode = 2'd0; bus.wa = '0; rand_wd(); bus.wd[TOP +: DW] = 32'h40;
    step();
    idle();
    #1;
    chk("dbg_s0_40", VW'(bus.dbg_s0), VW'(32'h40));
    step();
    idle();
    bus.we = 1'b1; bus.wmode = 2'd0; bus.wa = AW'(15); bus.wd[TOP +: DW] = 32'd5;
    bus.pc_in = 32'h100; bus.ra1 = AW'(15); bus.rd_vs1 = 1'b0;
    #1;
    chk("pc_alias_fwd", VW'(bus.rd1[TOP +: DW]), VW'(32'h100));
    step();
    idle();
    bus.pc_in = 32'h100; bus.ra1 = AW'(15); bus.rd_vs1 = 1'b0;
    #1;
    chk("pc_alias", VW'(bus.rd1[TOP +: DW]), VW'(32'h100));
    step();

    // Scoreboard: reserve, clear by write, collision keeps busy.
    idle();
    bus.rsv = 1'b1; bus.rsv_vs = 1'b1; bus.rsv_idx = AW'(4);
    bus.ra1 = AW'(4); bus.rd_vs1 = 1'b1;
    step();
    idle();
    bus.ra1 = AW'(4); bus.rd_vs1 = 1'b1;
    #1;
    chk("busy_set", VW'(bus.busy1), VW'(1'b1));
    bus.we = 1'b1; bus.wmode = 2'd1; bus.wa = AW'(4); bus.wmask = 16'($urandom); rand_wd();
    step();
    idle();
    bus.ra1 = AW'(4); bus.rd_vs1 = 1'b1;
    #1;
    chk("busy_clr", VW'(bus.busy1), VW'(1'b0));
    bus.we = 1'b1; bus.wmode = 2'd1; bus.wa = AW'(4); bus.wmask = 16'hFFFF; rand_wd();
    bus.rsv = 1'b1; bus.rsv_vs = 1'b1; bus.rsv_idx = AW'(4);
    step();
    idle();
    bus.ra1 = AW'(4); bus.rd_vs1 = 1'b1;
    #1;
    chk("busy_collide", VW'(bus.busy1), VW'(1'b1));
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.we      = 1'($urandom_range(0, 1));
      bus.wmode   = 2'($urandom_range(0, 3));
      bus.wa      = AW'($urandom_range(0, NVREG - 1));
      bus.wmask   = 16'($urandom);
      rand_wd();
      bus.rsv     = ($urandom_range(0, 2) == 0);
      bus.rsv_vs  = 1'($urandom_range(0, 1));
      bus.rsv_idx = AW'($urandom_range(0, NVREG - 1));
      bus.ra1     = ($urandom_range(0, 1) == 1) ? bus.wa : AW'($urandom_range(0, NVREG - 1));
      bus.ra2     = ($urandom_range(0, 1) == 1) ? bus.wa : AW'($urandom_range(0, NVREG - 1));
      bus.rd_vs1  = 1'($urandom_range(0, 1));
      bus.rd_vs2  = 1'($urandom_range(0, 1));
      bus.pc_in   = $urandom;
      step();
    end

    // Reset from RUN, then again at INIT cycle 7: sequencer restarts from zero.
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < NVREG; k++) begin
      if (k == 9) begin
        #1;
        chk("ready_not_9", VW'(bus.ready), VW'(1'b0));
      end
      step();
    end
    #1;
    chk("ready_after_rerun", VW'(bus.ready), VW'(1'b1));
    for (int v = 0; v < NVREG; v++) begin
      bus.ra1 = AW'(v); bus.rd_vs1 = 1'b1;
      bus.ra2 = AW'(NVREG - 1 - v); bus.rd_vs2 = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
